// File: rtl/iomem_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_timer_pkg
//  Description : Shared constants and helpers for the iomem_timer block.
//                - Register word offsets (iomem_addr[7:2])
//                - CTRL bit positions
//                - Byte-strobe merge function for partial writes
//  Revision    : 1.0 - initial release
// ============================================================================
package iomem_timer_pkg;

    // Register word offsets
    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_PRESC  = 6'h01;
    localparam logic [5:0] OFF_LOAD   = 6'h02;
    localparam logic [5:0] OFF_COUNT  = 6'h03;
    localparam logic [5:0] OFF_STATUS = 6'h04;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IRQEN  = 2;
    localparam int CTRL_W      = 3;

    // Replace the bytes of old_val selected by strb with those of new_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage : iomem_timer_pkg
`default_nettype wire

// File: rtl/iomem_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_timer_prescaler
//  Description : 16-bit prescaler. Emits a one-cycle tick every presc+1
//                cycles while run is high.
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                run         - count enable (CTRL.en)
//                clr         - restart the prescale count from 0
//                presc       - terminal count
//                tick        - high in the cycle where pc == presc
//  Revision    : 1.0 - initial release
// ============================================================================
module iomem_timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        clr,
    input  logic [15:0] presc,
    output logic        tick
);

    logic [15:0] r_pc;

    assign tick = run && (r_pc == presc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= 16'd0;
        end else if (clr) begin
            r_pc <= 16'd0;
        end else if (run) begin
            r_pc <= tick ? 16'd0 : r_pc + 16'd1;
        end
    end

endmodule : iomem_timer_prescaler
`default_nettype wire

// File: rtl/iomem_timer.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_timer
//  Description : Memory-mapped 32-bit countdown timer with prescaler,
//                auto-reload and level interrupt on the iomem bus.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                iomem_valid     - request valid (held until ready)
//                iomem_ready     - one-cycle completion pulse
//                iomem_wstrb     - byte write enables, 0 = read
//                iomem_addr      - byte address, window = addr[31:8]
//                iomem_wdata     - write data
//                iomem_rdata     - read data, valid with iomem_ready
//                irq             - expired & CTRL.irq_en
//  Revision    : 1.0 - initial release
// ============================================================================
module iomem_timer
    import iomem_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [15:0]       r_presc;
    logic [31:0]       r_load;
    logic [31:0]       r_count;
    logic              r_expired;
    logic              r_ready;
    logic [31:0]       r_rdata;

    logic [5:0]        w_off;
    logic              w_hit;
    logic              w_acc;
    logic              w_wr;
    logic              w_wr_ctrl;
    logic              w_wr_presc;
    logic              w_wr_load;
    logic              w_wr_count;
    logic              w_wr_status;
    logic              w_status_clr;
    logic [31:0]       w_rdmux;
    logic [31:0]       w_merged;
    logic              w_tick;
    logic              w_expire;
    logic [1:0]        w_unused_addr;

    assign w_unused_addr = iomem_addr[1:0];

    // Bus decode: accept on the edge that raises ready, never two in a row
    assign w_off       = iomem_addr[7:2];
    assign w_hit       = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign w_acc       = w_hit && !r_ready;
    assign w_wr        = w_acc && (iomem_wstrb != 4'b0000);
    assign w_wr_ctrl   = w_wr && (w_off == OFF_CTRL);
    assign w_wr_presc  = w_wr && (w_off == OFF_PRESC);
    assign w_wr_load   = w_wr && (w_off == OFF_LOAD);
    assign w_wr_count  = w_wr && (w_off == OFF_COUNT);
    assign w_wr_status = w_wr && (w_off == OFF_STATUS);
    assign w_status_clr = w_wr_status && iomem_wstrb[0] && iomem_wdata[0];

    // Current value of the addressed register; also the base for byte merges
    always_comb begin
        w_rdmux = 32'd0;
        case (w_off)
            OFF_CTRL:   w_rdmux = {{(32-CTRL_W){1'b0}}, r_ctrl};
            OFF_PRESC:  w_rdmux = {16'd0, r_presc};
            OFF_LOAD:   w_rdmux = r_load;
            OFF_COUNT:  w_rdmux = r_count;
            OFF_STATUS: w_rdmux = {31'd0, r_expired};
            default:    w_rdmux = 32'd0;
        endcase
    end

    assign w_merged = merge_bytes(w_rdmux, iomem_wdata, iomem_wstrb);

    iomem_timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (r_ctrl[CTRL_EN]),
        .clr   (w_wr_ctrl || w_wr_presc),
        .presc (r_presc),
        .tick  (w_tick)
    );

    // A CPU write to COUNT swallows a coincident tick, including its expiry
    assign w_expire = w_tick && (r_count == 32'd1) && !w_wr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready   <= 1'b0;
            r_rdata   <= 32'd0;
            r_ctrl    <= '0;
            r_presc   <= 16'd0;
            r_load    <= 32'd0;
            r_count   <= 32'd0;
            r_expired <= 1'b0;
        end else begin
            r_ready <= w_acc;
            if (w_acc) begin
                r_rdata <= w_rdmux;
            end

            // CPU write to CTRL takes precedence over one-shot auto-disable
            if (w_wr_ctrl) begin
                r_ctrl <= w_merged[CTRL_W-1:0];
            end else if (w_expire && !r_ctrl[CTRL_RELOAD]) begin
                r_ctrl[CTRL_EN] <= 1'b0;
            end

            if (w_wr_presc) begin
                r_presc <= w_merged[15:0];
            end

            if (w_wr_load) begin
                r_load <= w_merged;
            end

            if (w_wr_count) begin
                r_count <= w_merged;
            end else if (w_tick) begin
                if (r_count > 32'd1) begin
                    r_count <= r_count - 32'd1;
                end else if (r_count == 32'd1) begin
                    r_count <= r_ctrl[CTRL_RELOAD] ? r_load : 32'd0;
                end
            end

            // Set beats write-1-to-clear
            if (w_expire) begin
                r_expired <= 1'b1;
            end else if (w_status_clr) begin
                r_expired <= 1'b0;
            end
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign irq         = r_expired && r_ctrl[CTRL_IRQEN];

endmodule : iomem_timer
`default_nettype wire

// File: tb/tb_iomem_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iomem_timer
//  Description : Directed self-checking testbench for iomem_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iomem_timer;

    localparam logic [31:0] BASE     = 32'h0300_0000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_PRESC  = BASE + 32'h04;
    localparam logic [31:0] A_LOAD   = BASE + 32'h08;
    localparam logic [31:0] A_COUNT  = BASE + 32'h0C;
    localparam logic [31:0] A_STATUS = BASE + 32'h10;
    localparam logic [31:0] A_HOLE   = BASE + 32'h20;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        irq;

    int n_tests    = 0;
    int n_fail     = 0;
    int pulse_errs = 0;

    iomem_timer #(.BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // One bus transaction: accepted on the first posedge, ready must be high
    // right after it and low again one cycle later.
    task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, output logic [31:0] rd);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wdata;
        @(posedge clk);
        #1;
        if (iomem_ready !== 1'b1) pulse_errs++;
        rd = iomem_rdata;
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        @(posedge clk);
        #1;
        if (iomem_ready !== 1'b0) pulse_errs++;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        bus(addr, 4'b1111, data, dummy);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus(addr, 4'b0000, 32'd0, data);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] addrs [5];
        int          e0;
        addrs = '{A_CTRL, A_PRESC, A_LOAD, A_COUNT, A_STATUS};
        reset = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        iomem_addr  = 32'd0;
        iomem_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (irq !== 1'b0 || iomem_ready !== 1'b0 || iomem_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: irq=%b ready=%b rdata=%h, required 0/0/0",
                     irq, iomem_ready, iomem_rdata);
        end
        for (int i = 0; i < 5; i++) begin
            e0 = pulse_errs;
            rd(addrs[i], v);
            n_tests++;
            if (v !== 32'd0 || pulse_errs != e0) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got %h pulse_errs+%0d, required 0 and clean pulse",
                         i, v, pulse_errs - e0);
            end
        end
    endtask

    task automatic test_periodic();
        logic [31:0] v;
        logic        early;
        wr(A_PRESC, 32'd3);
        wr(A_LOAD,  32'd5);
        wr(A_COUNT, 32'd5);
        wr(A_CTRL,  32'h7);          // accepted at E0, returns after E1
        early = (irq !== 1'b0);
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i < 20 && irq !== 1'b0) early = 1'b1;
        end
        n_tests++;
        if (early) begin
            n_fail++;
            $display("FAIL periodic_early: irq rose before edge 20, required low until 20");
        end
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL periodic_edge20: irq=%b, required 1", irq);
        end
        rd(A_COUNT, v);              // sampled at E21
        n_tests++;
        if (v !== 32'd5) begin
            n_fail++;
            $display("FAIL periodic_reload: COUNT=%h, required 00000005", v);
        end
        wr(A_STATUS, 32'd1);         // accepted at E23
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL periodic_clear: irq=%b, required 0", irq);
        end
        early = 1'b0;
        for (int i = 25; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i < 40 && irq !== 1'b0) early = 1'b1;
        end
        n_tests++;
        if (early || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL periodic_edge40: early=%b irq=%b, required 0/1", early, irq);
        end
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'd1);
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        wr(A_PRESC, 32'd0);
        wr(A_COUNT, 32'd2);
        wr(A_CTRL,  32'h5);          // accepted at E0, COUNT=1 after E1
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_e1: irq=%b, required 0", irq);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_e2: irq=%b, required 1", irq);
        end
        rd(A_COUNT, v);
        n_tests++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL oneshot_count: COUNT=%h, required 00000000", v);
        end
        rd(A_CTRL, v);
        n_tests++;
        if (v !== 32'h4) begin
            n_fail++;
            $display("FAIL oneshot_ctrl: CTRL=%h, required 00000004", v);
        end
        repeat (5) @(posedge clk);
        rd(A_COUNT, v);
        n_tests++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL oneshot_stays: COUNT=%h, required 00000000", v);
        end
    endtask

    task automatic test_clear_collision();
        logic [31:0] v;
        wr(A_STATUS, 32'd1);
        wr(A_COUNT, 32'd3);
        wr(A_CTRL,  32'h5);          // E0; expiry lands on E3
        @(posedge clk);
        wr(A_STATUS, 32'd1);         // accepted at E3
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_irq: irq=%b, required 1", irq);
        end
        rd(A_STATUS, v);
        n_tests++;
        if (v !== 32'd1) begin
            n_fail++;
            $display("FAIL collision_status: STATUS=%h, required 00000001", v);
        end
        wr(A_STATUS, 32'd1);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_second_clear: irq=%b, required 0", irq);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] v;
        wr(A_LOAD, 32'h1122_3344);
        bus(A_LOAD, 4'b0010, 32'h0000_AB00, v);
        rd(A_LOAD, v);
        n_tests++;
        if (v !== 32'h1122_AB44) begin
            n_fail++;
            $display("FAIL byte_write: LOAD=%h, required 1122ab44", v);
        end
        wr(A_HOLE, 32'hFFFF_FFFF);
        rd(A_HOLE, v);
        n_tests++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL unmapped: read %h, required 00000000", v);
        end
    endtask

    task automatic test_nonhit();
        logic [31:0] v;
        logic        seen;
        seen = 1'b0;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0008;
        iomem_wstrb = 4'b1111;
        iomem_wdata = 32'hDEAD_BEEF;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (iomem_ready !== 1'b0) seen = 1'b1;
        end
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL nonhit_ready: ready pulsed, required none");
        end
        rd(A_LOAD, v);
        n_tests++;
        if (v !== 32'h1122_AB44) begin
            n_fail++;
            $display("FAIL nonhit_write: LOAD=%h, required 1122ab44", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic        seen;
        logic [31:0] addrs [5];
        addrs = '{A_CTRL, A_PRESC, A_LOAD, A_COUNT, A_STATUS};
        wr(A_PRESC, 32'd2);
        wr(A_COUNT, 32'd100);
        wr(A_CTRL,  32'h7);
        seen = 1'b0;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = A_LOAD;
        iomem_wstrb = 4'b0000;
        reset = 1'b1;
        @(posedge clk);
        #1;
        if (iomem_ready !== 1'b0) seen = 1'b1;
        @(negedge clk);
        iomem_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (iomem_ready !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen || irq !== 1'b0 || iomem_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: ready_seen=%b irq=%b rdata=%h, required 0/0/0",
                     seen, irq, iomem_rdata);
        end
        for (int i = 0; i < 5; i++) begin
            rd(addrs[i], v);
            n_tests++;
            if (v !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_mid_read[%0d]: got %h, required 00000000", i, v);
            end
        end
    endtask

    task automatic test_pulse_width();
        n_tests++;
        if (pulse_errs != 0) begin
            n_fail++;
            $display("FAIL ready_pulse: %0d malformed pulses, required 0", pulse_errs);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_clear_collision();
        test_byte_write();
        test_nonhit();
        test_reset_mid();
        test_pulse_width();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_iomem_timer
`default_nettype wire

// File: doc/iomem_timer.md
# iomem_timer

Memory-mapped 32-bit countdown timer with 16-bit prescaler, auto-reload and level interrupt. Sits directly downstream of the SoC's `iomem_*` bus and services CPU accesses in the `0x0300_0000` window. Drives the SoC's `irq_5` input.

## Interface

- `BASE_ADDR`, default `32'h0300_0000`: window base. Decode compares `iomem_addr[31:8]` only.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset.
- `iomem_valid` in 1: request valid, held until `iomem_ready`.
- `iomem_ready` out 1: one-cycle completion pulse.
- `iomem_wstrb` in 4: byte write enables. 0 means read.
- `iomem_addr` in 32: byte address. Register offset is `[7:2]`.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready`=1.
- `irq` out 1: level interrupt, `= expired & CTRL.irq_en`.

## Operation

- Registers (byte offset):
  - 0x00 CTRL: bit0 `en`, bit1 `reload`, bit2 `irq_en`. Other bits read 0.
  - 0x04 PRESC[15:0].
  - 0x08 LOAD[31:0].
  - 0x0C COUNT[31:0]. Writable.
  - 0x10 STATUS: bit0 `expired`. Write 1 to clear.
- Unmapped offsets inside the window read 0 and ignore writes.
- Writes honour `iomem_wstrb` per byte.
- Tick generation:
  - Prescaler counter `pc` runs only while `en`=1.
  - Tick when `pc==PRESC`, then `pc` returns to 0. Tick period is PRESC+1 cycles.
  - Writing CTRL or PRESC clears `pc`.
- On each tick:
  - If COUNT>1: COUNT decrements by 1.
  - If COUNT==1: set `expired`. COUNT becomes LOAD if `reload`=1, else 0 and `en` clears (one-shot).
  - If COUNT==0: no change, no event.
- Simultaneous events:
  - Expiry and a STATUS write-1 in the same cycle: set wins, `expired` stays 1.
  - A CPU write to COUNT and a tick in the same cycle: the write wins and that tick is lost.
  - A CPU write clearing `en` and an expiry in the same cycle: `en`=0 and `expired`=1.
- `reload`=1 with LOAD=0: COUNT goes to 0 and stays there. No further events.

## Timing

- A request hits when `iomem_valid` is high and `iomem_addr[31:8]==BASE_ADDR[31:8]`.
- `iomem_ready` is registered: `ready <= hit & !ready`. Latency is exactly 1 cycle. Ready is never high two cycles in a row.
- Register write and `rdata` capture occur on the same edge that raises `ready`.
- `iomem_rdata` holds its last value between accesses. It returns 0 on non-hit cycles is not required.
- Read-after-write to the same register on the next transaction returns the new value.
- Expiry:
  - `expired` and `irq` rise on the edge after the tick at which COUNT==1.
  - `irq` falls on the edge that completes the STATUS clear write.
- Reset values: `iomem_ready`=0, `iomem_rdata`=0, `irq`=0, CTRL=0, PRESC=0, LOAD=0, COUNT=0, `expired`=0, `pc`=0.
- Reset asserted mid-access aborts it. No `ready` pulse follows for that request.
- A non-hit `iomem_valid` is ignored entirely. The SoC owns timeout and multiplexing.

## Structure

- Package `iomem_timer_pkg` holds:
  - Offsets `OFF_CTRL/PRESC/LOAD/COUNT/STATUS` (6-bit word indices).
  - CTRL bit positions `CTRL_EN`, `CTRL_RELOAD`, `CTRL_IRQEN`.
  - A byte-strobe merge function.
- Sub-module `iomem_timer_prescaler` contains the 16-bit `pc` counter. Ports: `clk`, `reset`, `run`, `clr`, `presc`, output `tick`.
- The top level holds:
  - Bus decode, ready/rdata registers.
  - Register file.
  - Count/expiry logic.
  - About 200 lines total.

## Test plan

- Reset, then read all five registers. All read 0, `irq`=0, and each `ready` pulse is exactly 1 cycle wide.
- Write PRESC=3, LOAD=5, COUNT=5, then CTRL=0x7. `expired` and `irq` rise 20 cycles after CTRL is written (±1 edge, exact value checked). COUNT reloads to 5 and repeats every 20 cycles.
- One-shot: CTRL=0x5, PRESC=0, COUNT=2. Expiry occurs after 2 cycles, then COUNT=0, CTRL reads 0x4 and the counter stays at 0.
- Clear collision: align a STATUS write of 1 with the expiry tick. `expired` remains 1. A second clear write drops `irq`.
- Byte write: wstrb=4'b0010, wdata=0x0000AB00 to LOAD=0x11223344 gives LOAD=0x1122AB44. A write to offset 0x20 is ignored and reads back 0.
- Address `0x0400_0000` with `iomem_valid` held for 4 cycles: no `ready` pulse. Assert `reset` while a hit is pending: no `ready` pulse and all state returns to reset values.
